serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset; rst=0 resets the block immediately, independent of clk.
REQ-004 pload  input  1  SHALL be a parallel-load/start strobe: captures adata and bdata and begins an operation.
REQ-005 adata  input  WIDTH  SHALL be the minuend (A), unsigned.
REQ-006 bdata  input  WIDTH  SHALL be the subtrahend (B), unsigned.
REQ-007 enable  input  1  SHALL be the per-bit advance qualifier; 0 stalls the operation.
REQ-008 pout  output  WIDTH  SHALL be the result shift register (A-B mod 2^WIDTH once done=1).
REQ-009 bout  output  1  SHALL be the final borrow; 1 means A < B.
REQ-010 busy  output  1  SHALL be high while in state SHIFT.
REQ-011 done  output  1  SHALL be high while in state DONE.
REQ-012 zero  output  1  SHALL be high when done=1 and pout is all zeros; it SHALL be 0 otherwise.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE; busy and done SHALL decode from state only.
REQ-014 In IDLE or DONE, pload=1 at a clock edge SHALL do all of the following: load A into opa and B into opb; clear pout, the borrow flop and the bit counter; enter SHIFT.
REQ-015 pload SHALL be ignored in SHIFT; the operation in flight continues unaffected.
REQ-016 In SHIFT with enable=1, each edge SHALL compute d = opa[0] ^ opb[0] ^ brw.
REQ-017 Each such edge SHALL compute brw_next = (~opa[0] & opb[0]) | (~(opa[0] ^ opb[0]) & brw).
REQ-018 Each such edge SHALL shift pout right one place with d inserted at the MSB, so results are LSB-first.
REQ-019 Each such edge SHALL rotate opa and opb right one place, increment the counter and store brw_next.
REQ-020 In SHIFT with enable=0, opa, opb, pout, brw and the counter SHALL all hold.
REQ-021 The edge that processes the WIDTH-th enabled bit SHALL move the FSM to DONE; done SHALL rise on that same edge.
REQ-022 Latency SHALL be exactly WIDTH enabled cycles after the pload edge; with enable held high, done is 1 after edge WIDTH+1, counting the pload edge as edge 1.
REQ-023 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within an operation.
REQ-024 bout SHALL equal brw; it is valid when done=1 and SHALL hold until the next pload.
REQ-025 The block SHALL stay in DONE, holding pout and bout, until pload=1; it SHALL then restart per REQ-014 with no idle cycle between operations.
REQ-026 In IDLE with pload=0, the block SHALL hold all state.
REQ-027 enable SHALL have no effect in IDLE or DONE.
REQ-028 pout SHALL show the partial result during SHIFT; consumers SHALL sample it only while done=1.

Reset
REQ-029 While rst=0, the state SHALL be IDLE and opa, opb, pout, brw and the counter SHALL be 0.
REQ-030 While rst=0, every output SHALL be 0: pout=0, bout=0, busy=0, done=0, zero=0.
REQ-031 Reset asserted mid-operation SHALL abandon the operation immediately, without waiting for a clock edge.
REQ-032 After rst returns to 1, the first edge SHALL act per IDLE rules.

Verification
REQ-033 A=8'd100, B=8'd37, enable=1 -> done on edge 9 after pload, pout=8'd63, bout=0, zero=0.
REQ-034 A=8'd5, B=8'd10 -> pout=8'd251, bout=1.
REQ-035 A=B=8'h55 -> pout=8'h00, bout=0, zero=1.
REQ-036 A=8'hFF, B=8'h01, enable low for 3 cycles mid-operation -> done 3 cycles later than unstalled, pout=8'hFE, bout=0.
REQ-037 rst=0 after 4 enabled bits -> outputs 0 immediately without a clock edge; a fresh A=8'd0, B=8'd1 run yields pout=8'hFF, bout=1.
REQ-038 pload with new operands at bit 3 of A=8'd20, B=8'd7 -> ignored, result 8'd13; a pload in DONE with no gap starts the next operation correctly.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor -- bit-serial unsigned subtractor, A - B mod 2^WIDTH.
//
// pload (in IDLE or DONE) captures adata/bdata and starts an operation.
// Each enabled cycle in SHIFT consumes one bit of each operand LSB-first
// and shifts the difference bit into the MSB of pout. After WIDTH enabled
// cycles the FSM enters DONE and holds pout/bout until the next pload.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   pload   parallel-load / start strobe (ignored while busy)
//   adata   minuend A
//   bdata   subtrahend B
//   enable  per-bit advance qualifier; 0 stalls SHIFT
//   pout    result shift register (valid while done=1)
//   bout    final borrow (1 means A < B)
//   busy    high in SHIFT
//   done    high in DONE
//   zero    high in DONE when pout is all zeros
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pload,
  input  logic [WIDTH-1:0] adata,
  input  logic [WIDTH-1:0] bdata,
  input  logic             enable,
  output logic [WIDTH-1:0] pout,
  output logic             bout,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             start, step, d, brw_nxt;

  assign start   = pload && (state != SHIFT);
  assign step    = (state == SHIFT) && enable;
  // full-subtractor cell on the current LSBs
  assign d       = opa[0] ^ opb[0] ^ brw;
  assign brw_nxt = (~opa[0] & opb[0]) | (~(opa[0] ^ opb[0]) & brw);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pload) state_nxt = SHIFT;
      // last bit moves straight to DONE so done rises on that same edge
      SHIFT:   if (enable && cnt == LAST) state_nxt = DONE;
      DONE:    if (pload) state_nxt = SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa  <= '0;
      opb  <= '0;
      pout <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      opa  <= adata;
      opb  <= bdata;
      pout <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (step) begin
      // rotate rather than shift so the operand registers never lose data
      opa  <= {opa[0], opa[WIDTH-1:1]};
      opb  <= {opb[0], opb[WIDTH-1:1]};
      pout <= {d, pout[WIDTH-1:1]};
      brw  <= brw_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign bout = brw;
  assign zero = done && (pout == '0);

endmodule
